// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared state encoding and sizing constants for the imem loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_MEM_WORDS  = 256;
    localparam int C_BYTE_CNT_W = 2;
    localparam int C_IDX_W      = $clog2(C_MEM_WORDS);

    // A count byte of zero means a full memory image.
    function automatic logic [C_IDX_W:0] decode_count(input logic [7:0] b);
        return (b == 8'd0) ? (C_IDX_W + 1)'(C_MEM_WORDS) : (C_IDX_W + 1)'(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream input and instruction-memory write port bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// Module   : imem_word_packer
// Purpose  : Packs a byte stream big-endian into 32-bit words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_word_packer
    import imem_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        i_clr,
    input  wire logic        i_byte_en,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_word,
    output logic             o_full
);

    logic [23:0]             r_shift;
    logic [C_BYTE_CNT_W-1:0] r_cnt;

    // The fourth byte completes the word combinationally so the write can be
    // registered on the same edge that accepts it.
    assign o_full = i_byte_en && (r_cnt == '1);
    assign o_word = {r_shift, i_byte};

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_en) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + C_BYTE_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a counted byte stream into instruction memory, holding the
//            core in reset until the image is complete.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    input  wire logic      start,
    imem_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           cpu_hold
);

    state_t             r_state;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_IDX_W:0]   r_n;
    logic               r_in_ready;
    logic               r_wr_en;
    logic [31:0]        r_wr_addr;
    logic [31:0]        r_wr_data;
    logic               r_busy;
    logic               r_done;
    logic               r_hold;

    logic               w_take;
    logic               w_byte_en;
    logic               w_full;
    logic               w_last;
    logic [31:0]        w_word;

    assign w_take    = bus.in_valid && r_in_ready;
    assign w_byte_en = w_take && (r_state == ST_DATA);
    assign w_last    = ({1'b0, r_idx} == (r_n - (C_IDX_W + 1)'(1)));

    imem_word_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (r_state == ST_IDLE),
        .i_byte_en (w_byte_en),
        .i_byte    (bus.in_data),
        .o_word    (w_word),
        .o_full    (w_full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_n        <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hold     <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_COUNT;
                        r_idx      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold     <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (w_take) begin
                        r_n     <= decode_count(bus.in_data);
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_full) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_word;
                        r_wr_addr <= BASE_ADDR + {{(30 - C_IDX_W){1'b0}}, r_idx, 2'b00};
                        r_idx     <= r_idx + C_IDX_W'(1);
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_hold  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cpu_hold     = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader (two instances, two bases).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam logic [31:0] A_BASE = 32'h0000_0000;
    localparam logic [31:0] B_BASE = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy_a, done_a, hold_a;
    logic busy_b, done_b, hold_b;

    always #5 clk = ~clk;

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    assign ifb.in_valid = ifa.in_valid;
    assign ifb.in_data  = ifa.in_data;

    imem_loader #(.BASE_ADDR(A_BASE)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(ifa.master),
        .busy(busy_a), .done(done_a), .cpu_hold(hold_a)
    );

    imem_loader #(.BASE_ADDR(B_BASE)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(ifb.master),
        .busy(busy_b), .done(done_b), .cpu_hold(hold_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Scoreboard: expected {addr, data} per instance
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    // Reference model of the load protocol
    int          m_st  = 0;
    int          m_cnt = 0;
    int          m_k   = 0;
    int          m_n   = 0;
    logic [31:0] m_word = '0;

    task automatic model_step(input logic s, input logic v, input logic [7:0] d);
        case (m_st)
            0: if (s) begin m_st = 1; m_k = 0; m_cnt = 0; end
            1: if (v) begin m_n = (d == 8'd0) ? 256 : int'(d); m_st = 2; end
            2: if (v) begin
                m_word = {m_word[23:0], d};
                m_cnt++;
                if (m_cnt == 4) begin
                    qa.push_back({A_BASE + 32'(m_k * 4), m_word});
                    qb.push_back({B_BASE + 32'(m_k * 4), m_word});
                    m_cnt = 0;
                    m_k++;
                    if (m_k == m_n) m_st = 3;
                end
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start        = s;
        ifa.in_valid = v;
        ifa.in_data  = d;
        model_step(s, v, d);
        @(posedge clk);
        #1;
    endtask

    // Write monitors
    int          wr_a = 0, wr_b = 0, dn_a = 0;
    logic [31:0] last_addr_a = '0, last_addr_b = '0, last_data_b = '0;

    always @(negedge clk) begin
        if (ifa.wr_en) begin
            wr_a++;
            last_addr_a = ifa.wr_addr;
            if (qa.size() == 0) begin
                n_checks++;
                $display("FAIL wr_a_unexpected: got addr %h data %h, required no write", ifa.wr_addr, ifa.wr_data);
            end else chk("wr_a", {ifa.wr_addr, ifa.wr_data}, qa.pop_front());
        end
        if (ifb.wr_en) begin
            wr_b++;
            last_addr_b = ifb.wr_addr;
            last_data_b = ifb.wr_data;
            if (qb.size() == 0) begin
                n_checks++;
                $display("FAIL wr_b_unexpected: got addr %h data %h, required no write", ifb.wr_addr, ifb.wr_data);
            end else chk("wr_b", {ifb.wr_addr, ifb.wr_data}, qb.pop_front());
        end
        if (done_a) dn_a++;
    end

    typedef struct {
        logic       s, v;
        logic [7:0] d;
        logic       rdy, bsy, wr, dn, hold;
    } vec_t;

    vec_t        tbl[13];
    logic [7:0]  stream[9];
    int          w0, d0;

    initial begin
        tbl = '{
            '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
        };
        stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};

        reset_n = 1'b0; start = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   ifa.in_ready, 0);
        chk("rst_busy",    busy_a, 0);
        chk("rst_done",    done_a, 0);
        chk("rst_hold",    hold_a, 1);
        chk("rst_wr_en",   ifa.wr_en, 0);
        chk("rst_wr_addr", ifa.wr_addr, 0);
        chk("rst_wr_data", ifa.wr_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back two-word load, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("t%0d_ready", i), ifa.in_ready, tbl[i].rdy);
            chk($sformatf("t%0d_busy", i),  busy_a,       tbl[i].bsy);
            chk($sformatf("t%0d_wr_en", i), ifa.wr_en,    tbl[i].wr);
            chk($sformatf("t%0d_done", i),  done_a,       tbl[i].dn);
            chk($sformatf("t%0d_hold", i),  hold_a,       tbl[i].hold);
        end

        // Same stream with three stall cycles between bytes
        d0 = dn_a;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, stream[i]);
            if (i < 8) begin
                chk("stall_busy_byte", busy_a, 1);
                for (int j = 0; j < 3; j++) begin
                    drive(1'b0, 1'b0, 8'hEE);
                    chk("stall_busy_gap", busy_a, 1);
                    chk("stall_hold", hold_a, 1);
                end
            end
        end
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        chk("stall_done_pulses", dn_a - d0, 1);
        chk("stall_hold_after", hold_a, 0);

        // Count byte 0 -> 256 words
        w0 = wr_a; d0 = dn_a;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 1024; i++) drive(1'b0, 1'b1, 8'($urandom));
        repeat (3) drive(1'b0, 1'b1, 8'h00);
        chk("full_writes", wr_a - w0, 256);
        chk("full_last_addr", last_addr_a, 32'h0000_03FC);
        chk("full_done_pulses", dn_a - d0, 1);

        // Single word, non-zero base on instance B
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h8C);
        drive(1'b0, 1'b1, 8'h0B);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("base_addr_b", last_addr_b, 32'h0000_0100);
        chk("base_data_b", last_data_b, 32'h8C0B_0000);

        // Reset after six bytes of a two-word load
        w0 = wr_a;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h02);
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        drive(1'b0, 1'b1, 8'h33);
        drive(1'b0, 1'b1, 8'h44);
        drive(1'b0, 1'b1, 8'h55);
        @(negedge clk);
        reset_n = 1'b0; ifa.in_valid = 1'b1; ifa.in_data = 8'h66;
        m_st = 0; m_cnt = 0; m_k = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_wr_en", ifa.wr_en, 0);
        chk("rst_mid_hold",  hold_a, 1);
        chk("rst_mid_ready", ifa.in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 8'h77);
        chk("rst_mid_writes", wr_a - w0, 1);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'hDE);
        drive(1'b0, 1'b1, 8'hAD);
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        chk("rst_reload_addr", last_addr_a, A_BASE);
        drive(1'b0, 1'b0, 8'h00);

        // Start pulsed mid-load, then held across DONE->IDLE
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h02);
        drive(1'b0, 1'b1, 8'hA1);
        drive(1'b1, 1'b1, 8'hA2);
        drive(1'b0, 1'b1, 8'hA3);
        drive(1'b0, 1'b1, 8'hA4);
        drive(1'b1, 1'b1, 8'hB1);
        drive(1'b0, 1'b1, 8'hB2);
        drive(1'b0, 1'b1, 8'hB3);
        drive(1'b1, 1'b1, 8'hB4);
        chk("restart_busy_done_state", busy_a, 0);
        drive(1'b1, 1'b0, 8'h00);
        chk("restart_done", done_a, 1);
        chk("restart_idle_busy", busy_a, 0);
        drive(1'b1, 1'b0, 8'h00);
        chk("restart_busy", busy_a, 1);
        chk("restart_hold", hold_a, 1);
        chk("restart_ready", ifa.in_ready, 1);

        @(negedge clk);
        reset_n = 1'b0; start = 1'b0; ifa.in_valid = 1'b0;
        m_st = 0; m_cnt = 0; m_k = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00000000: byte address of the first word written; word-aligned.
REQ-002 clk  input  1  rising-edge system clock; all state updates on this edge.
REQ-003 reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 start  input  1  level; sampled in IDLE only; begins a load session.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  program byte.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 wr_en  output  1  one-cycle write strobe to instruction memory write port.
REQ-009 wr_addr  output  32  byte address of the write; bits [1:0] always 0; memory indexes with [9:2].
REQ-010 wr_data  output  32  instruction word to write.
REQ-011 busy  output  1  high in COUNT and DATA states.
REQ-012 done  output  1  one-cycle pulse at end of a load.
REQ-013 cpu_hold  output  1  holds the single-cycle core (PC) in reset while the program image is invalid.

Function
REQ-014 A byte transfer occurs on a cycle with in_valid and in_ready both high; no other cycle consumes a byte.
REQ-015 States: IDLE, COUNT, DATA, DONE; encoding binary, 2 bits.
REQ-016 IDLE: in_ready=0; start=1 -> COUNT next cycle, cpu_hold set to 1 on the same edge.
REQ-017 COUNT: in_ready=1; the accepted byte is word count N; N=0 means 256; N=1..255 literal; -> DATA.
REQ-018 DATA: in_ready=1; bytes packed big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-019 On the edge accepting a 4th byte: wr_en=1, wr_data=packed word, wr_addr=BASE_ADDR+4*k (k = word index from 0) registered, visible for exactly the following cycle.
REQ-020 Word index k increments after each write; wr_addr arithmetic is 32-bit, wraps modulo 2^32.
REQ-021 After the write of word N-1 is registered -> DONE; no further bytes accepted (in_ready=0 from that edge).
REQ-022 DONE lasts one cycle: done=1, cpu_hold=0 on the following edge onward; -> IDLE.
REQ-023 Stalls (in_valid low) of any length anywhere in COUNT/DATA SHALL not alter the packed bytes, index or state.
REQ-024 start while not in IDLE is ignored; start held high across DONE->IDLE begins a new session the cycle after returning to IDLE.
REQ-025 wr_en low whenever no write is issued; wr_addr/wr_data hold last value when wr_en=0.
REQ-026 Maximum throughput: one byte per cycle; no back-pressure is ever generated inside COUNT/DATA.

Reset
REQ-027 reset_n low at a clock edge: state=IDLE, byte counter=0, word index=0, N=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, cpu_hold=1.
REQ-028 Reset mid-load discards partial words; no wr_en is issued on or after the reset edge; a new session restarts at word index 0.

Structure
REQ-029 State encodings, MEM_WORDS=256 and the byte-count width constant SHALL live in the shared imem package/include.
REQ-030 Byte packing (shift register + 2-bit byte counter + full flag) SHALL be one sub-module, imem_word_packer; FSM, index counter and write port stay in imem_loader.

Verification
REQ-031 Back-to-back stream 02,20,08,00,05,20,09,00,0A after start -> wr (0x0,0x20080005), wr (0x4,0x2009000A), done one cycle after second wr_en, cpu_hold 0 thereafter.
REQ-032 Same stream with in_valid low 3 cycles between every byte -> identical writes and data; busy stays high throughout.
REQ-033 Count byte 00 then 1024 bytes -> exactly 256 writes, last wr_addr 0x000003FC, single done pulse.
REQ-034 BASE_ADDR=32'h00000100, N=1, bytes 8C,0B,00,00 -> single write (0x100, 0x8C0B0000).
REQ-035 reset_n low after 6 bytes of a N=2 load -> only word 0 written, no second wr_en, cpu_hold=1, in_ready=0; fresh load then writes from address BASE_ADDR.
REQ-036 in_valid high with start low in IDLE, and start pulsed during DATA -> no bytes consumed in IDLE, session unaffected by mid-load start.
